sevseg_scan_decoder: RTL and testbench

Receive-side counterpart of the hex-to-seven-segment encoder. It watches a time-multiplexed seven-segment bus, made of segment lines plus one-hot digit strobes. It waits for each digit to be stable, decodes each segment pattern back to a hex nibble, and assembles one full scan (digit 0..NDIG-1) into a hex word. The word is handed downstream on a valid/ready handshake. Typical use: loopback checking of the display driver and capturing panel readouts.

---
 rtl/sevseg_pkg.sv | 40 ++++
 rtl/sevseg_pattern_dec.sv | 22 ++
 rtl/sevseg_scan_decoder.sv | 159 +++++++++++++++
 tb/tb_sevseg_scan_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared seven-segment definitions: segment bit indices, FSM state type and the
// hex<->segment pattern table used by both the encoder and the scan decoder.
package sevseg_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } scan_state_t;

  // Segment order {a,b,c,d,e,f,g}, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    case (hex)
      4'h0: hex_to_seg = 7'b1111110;
      4'h1: hex_to_seg = 7'b0110000;
      4'h2: hex_to_seg = 7'b1101101;
      4'h3: hex_to_seg = 7'b1111001;
      4'h4: hex_to_seg = 7'b0110011;
      4'h5: hex_to_seg = 7'b1011011;
      4'h6: hex_to_seg = 7'b1011111;
      4'h7: hex_to_seg = 7'b1110000;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1111011;
      4'hA: hex_to_seg = 7'b1110111;
      4'hB: hex_to_seg = 7'b0011111;
      4'hC: hex_to_seg = 7'b1001110;
      4'hD: hex_to_seg = 7'b0111101;
      4'hE: hex_to_seg = 7'b1001111;
      default: hex_to_seg = 7'b1000111;
    endcase
  endfunction

endpackage

// File: rtl/sevseg_pattern_dec.sv
// Purely combinational inverse of the segment table: pattern -> {illegal, nibble}.
// Patterns outside the table decode to nibble 0 with illegal set.
module sevseg_pattern_dec
  import sevseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       illegal,
  output logic [3:0] nibble
);

  always_comb begin
    illegal = 1'b1;
    nibble  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == hex_to_seg(4'(i))) begin
        illegal = 1'b0;
        nibble  = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sevseg_scan_decoder.sv
// Watches a multiplexed seven-segment bus, captures each digit once it has been stable
// STABLE_CYC cycles, and emits a full scan as a hex word on valid/ready (optional SEVSEG_ERR_CNT_EN).
module sevseg_scan_decoder
  import sevseg_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_en,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [4*NDIG-1:0] out_value,
  output logic              out_err,
  output logic              overrun
`ifdef SEVSEG_ERR_CNT_EN
  ,output logic [7:0]       err_cnt
`endif
);

  localparam int          IW     = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0]  STAB   = 8'(STABLE_CYC);
  localparam logic [8:0]  CAP_AT = 9'(STABLE_CYC - 1);

  logic [6:0]        seg_q;
  logic [NDIG-1:0]   dig_q;
  logic [7:0]        stab_cnt;
  logic              cap_done;
  logic              same, onehot, capture;
  logic [8:0]        cnt_inc;
  logic [IW-1:0]     cap_idx;
  logic              dec_ill;
  logic [3:0]        dec_nib;

  scan_state_t       state, state_nxt;
  logic [IW-1:0]     exp_idx, exp_nxt;
  logic [4*NDIG-1:0] frame_buf, buf_nxt;
  logic              frame_err, ferr_nxt;
  logic              frame_done;

  sevseg_pattern_dec u_dec (
    .seg     (seg_in),
    .illegal (dec_ill),
    .nibble  (dec_nib)
  );

  assign same    = ({seg_in, dig_en} == {seg_q, dig_q});
  assign onehot  = $onehot(dig_en);
  assign cnt_inc = {1'b0, stab_cnt} + 9'd1;
  // Fires on the cycle the counter is about to reach STABLE_CYC-1, i.e. the STABLE_CYC-th cycle held.
  assign capture = same && onehot && !cap_done && (cnt_inc >= CAP_AT);

  always_comb begin
    cap_idx = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (dig_en[k]) cap_idx = IW'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= '0;
      dig_q    <= '0;
      stab_cnt <= '0;
      cap_done <= 1'b0;
    end else begin
      seg_q <= seg_in;
      dig_q <= dig_en;
      if (!same || !onehot) begin
        stab_cnt <= '0;
        cap_done <= 1'b0;
      end else begin
        if (stab_cnt != STAB) stab_cnt <= stab_cnt + 8'd1;
        if (capture) cap_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      exp_idx   <= '0;
      frame_buf <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      exp_idx   <= exp_nxt;
      frame_buf <= buf_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    exp_nxt    = exp_idx;
    buf_nxt    = frame_buf;
    ferr_nxt   = frame_err;
    frame_done = 1'b0;
    if (capture) begin
      // Digit 0 always (re)starts a frame, whether hunting or mid-collection.
      if (cap_idx == '0) begin
        buf_nxt[3:0] = dec_nib;
        ferr_nxt     = dec_ill;
        if (NDIG == 1) begin
          frame_done = 1'b1;
          state_nxt  = HUNT;
        end else begin
          exp_nxt   = IW'(1);
          state_nxt = COLLECT;
        end
      end else if (state == COLLECT) begin
        if (cap_idx == exp_idx) begin
          buf_nxt[4*int'(exp_idx) +: 4] = dec_nib;
          ferr_nxt = frame_err | dec_ill;
          if (exp_idx == IW'(NDIG - 1)) begin
            frame_done = 1'b1;
            state_nxt  = HUNT;
          end else begin
            exp_nxt = exp_idx + IW'(1);
          end
        end else begin
          state_nxt = HUNT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_value <= buf_nxt;
        out_err   <= ferr_nxt;
      end else begin
        if (frame_done) overrun <= 1'b1;
        if (out_ready) out_valid <= 1'b0;
      end
    end
  end

`ifdef SEVSEG_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (capture && dec_ill && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// Self-checking bench for sevseg_scan_decoder (NDIG=4, STABLE_CYC=4): table-driven scans
// plus hand sequences for latency, short holds, discards, overrun and mid-frame reset.
module tb_sevseg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_value;
  logic        out_err;
  logic        overrun;
`ifdef SEVSEG_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  sevseg_scan_decoder #(.NDIG(4), .STABLE_CYC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_en    (dig_en),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_err   (out_err),
    .overrun   (overrun)
`ifdef SEVSEG_ERR_CNT_EN
    ,.err_cnt  (err_cnt)
`endif
  );

  localparam logic [6:0] SEGS [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef struct {
    logic [15:0] nibs;
    logic [3:0]  bad;
    logic [6:0]  badpat;
    int          hold;
    logic [15:0] exp_val;
    logic        exp_err;
    int          ecnt;
  } vec_t;

  typedef struct {
    logic [15:0] v;
    logic        e;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  int   ovr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
    seg_in = s;
    dig_en = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [15:0] nibs, input logic [3:0] bad, input logic [6:0] badpat,
                      input int hold);
    for (int k = 0; k < 4; k++)
      drive(bad[k] ? badpat : SEGS[nibs[4*k +: 4]], 4'(1 << k), hold);
    drive(7'h00, 4'h0, 4);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (overrun) ovr_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected no word", out_value);
        end else begin
          e = sb.pop_front();
          chk("word_value", {16'h0, out_value}, {16'h0, e.v});
          chk("word_err", {31'h0, out_err}, {31'h0, e.e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hb;
    int ob;

    vecs[0] = '{16'h0123, 4'b0000, 7'h00,       6, 16'h0123, 1'b0, 0};
    vecs[1] = '{16'h4021, 4'b0100, 7'b1010101,  5, 16'h4021, 1'b1, 1};
    vecs[2] = '{16'hEDCB, 4'b0000, 7'h00,       4, 16'hEDCB, 1'b0, 1};
    vecs[3] = '{16'h8888, 4'b0000, 7'h00,       7, 16'h8888, 1'b0, 1};
    vecs[4] = '{16'h5907, 4'b0010, 7'b0000000,  5, 16'h5907, 1'b1, 2};

    seg_in    = 7'h00;
    dig_en    = 4'h0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_value", {16'h0, out_value}, 32'h0);
    chk("rst_err", {31'h0, out_err}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
`ifdef SEVSEG_ERR_CNT_EN
    chk("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First-word latency: valid must rise on the 4th edge after digit 3 appears.
    sb.push_back('{16'hF0A3, 1'b0});
    drive(SEGS[3],  4'b0001, 6);
    drive(SEGS[10], 4'b0010, 6);
    drive(SEGS[0],  4'b0100, 6);
    seg_in = SEGS[15];
    dig_en = 4'b1000;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd4);
    repeat (2) @(posedge clk);
    #1;
    drive(7'h00, 4'h0, 4);

    for (int i = 0; i < 5; i++) begin
      sb.push_back('{vecs[i].exp_val, vecs[i].exp_err});
      scan(vecs[i].nibs, vecs[i].bad, vecs[i].badpat, vecs[i].hold);
`ifdef SEVSEG_ERR_CNT_EN
      chk("err_cnt", {24'h0, err_cnt}, 32'(vecs[i].ecnt));
`endif
    end

    // Three-cycle holds never capture; four-cycle holds do.
    hb = hs_cnt;
    scan(16'h2222, 4'b0000, 7'h00, 3);
    repeat (4) @(posedge clk);
    #1;
    chk("short_hold_no_word", 32'(hs_cnt), 32'(hb));
    sb.push_back('{16'h1357, 1'b0});
    scan(16'h1357, 4'b0000, 7'h00, 4);

    // Out-of-order digit 3 must drop back to HUNT, so a later 2,3 completes nothing.
    hb = hs_cnt;
    drive(SEGS[1], 4'b0001, 5);
    drive(SEGS[1], 4'b0010, 5);
    drive(SEGS[1], 4'b1000, 5);
    drive(SEGS[1], 4'b0100, 5);
    drive(SEGS[1], 4'b1000, 5);
    drive(7'h00, 4'h0, 6);
    chk("discard_no_word", 32'(hs_cnt), 32'(hb));
    sb.push_back('{16'h1111, 1'b0});
    scan(16'h1111, 4'b0000, 7'h00, 5);

    // Backpressure: second frame dropped with a single overrun pulse.
    out_ready = 1'b0;
    ob = ovr_cnt;
    sb.push_back('{16'h8765, 1'b0});
    scan(16'h8765, 4'b0000, 7'h00, 5);
    scan(16'h9999, 4'b0000, 7'h00, 5);
    chk("overrun_pulses", 32'(ovr_cnt - ob), 32'd1);
    chk("held_valid", {31'h0, out_valid}, 32'h1);
    chk("held_value", {16'h0, out_value}, 32'h8765);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_drop", {31'h0, out_valid}, 32'h0);
    drive(7'h00, 4'h0, 2);

    // Asynchronous reset mid-frame while a word is held.
    out_ready = 1'b0;
    scan(16'h4321, 4'b0000, 7'h00, 5);
    chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    chk("pre_rst_value", {16'h0, out_value}, 32'h4321);
    drive(SEGS[6], 4'b0001, 5);
    drive(SEGS[7], 4'b0010, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_value", {16'h0, out_value}, 32'h0);
    chk("mid_rst_err", {31'h0, out_err}, 32'h0);
    chk("mid_rst_overrun", {31'h0, overrun}, 32'h0);
`ifdef SEVSEG_ERR_CNT_EN
    chk("mid_rst_err_cnt", {24'h0, err_cnt}, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(7'h00, 4'h0, 2);
    sb.push_back('{16'hC0DE, 1'b0});
    scan(16'hC0DE, 4'b0000, 7'h00, 5);

    for (int i = 0; i < 60 && sb.size() > 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
